// File: rtl/demux_1x3_reg.sv
// Registered 1-to-3 stream demultiplexer: one holding stage steers each accepted
// beat to one of three consumers; select code 2'b11 discards the beat and counts it.
module demux_1x3_reg #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            i_Sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            out_valid,
  input  logic [2:0]            out_ready,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  busy
);

  // Handshake: a beat moves on a rising edge when valid and ready are both high.
  // in_ready never looks at in_valid or i_Sel; it may follow out_ready combinationally.

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [2:0]            hold_dest_q, hold_dest_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic       drain;
  logic       accept;
  logic       sel_drop;
  logic [2:0] sel_onehot;

  always_comb begin
    sel_onehot = 3'b000;
    case (i_Sel)
      2'b00:   sel_onehot = 3'b001;
      2'b01:   sel_onehot = 3'b010;
      2'b10:   sel_onehot = 3'b100;
      default: sel_onehot = 3'b000;
    endcase
  end

  assign sel_drop = (i_Sel == 2'b11);
  assign drain    = (state_q == FULL) && ((hold_dest_q & out_ready) != 3'b000);
  assign in_ready = i_rst_n && ((state_q == EMPTY) || drain);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_dest_d = hold_dest_q;
    drop_cnt_d  = drop_cnt_q;

    if (drain) begin
      state_d = EMPTY;
    end

    if (accept) begin
      if (sel_drop) begin
        if (drop_cnt_q != CNT_MAX) begin
          drop_cnt_d = drop_cnt_q + 1'b1;
        end
      end else begin
        // A new beat may replace the one leaving in the same cycle.
        state_d     = FULL;
        hold_data_d = in_data;
        hold_dest_d = sel_onehot;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= EMPTY;
      hold_data_q <= '0;
      hold_dest_q <= 3'b000;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_dest_q <= hold_dest_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid = (state_q == FULL) ? hold_dest_q : 3'b000;
  assign out_data  = (state_q == FULL) ? hold_data_q : '0;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (state_q == FULL);

endmodule

// File: tb/tb_demux_1x3_reg.sv
// Directed bench for demux_1x3_reg: a beat-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_demux_1x3_reg;

  localparam int DW = 12;
  localparam int CW = 8;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic          i_clk;
  logic          i_rst_n;
  logic [DW-1:0] in_data;
  logic [1:0]    i_Sel;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    out_valid;
  logic [2:0]    out_ready;
  logic [CW-1:0] drop_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;

  demux_1x3_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .in_data  (in_data),
    .i_Sel    (i_Sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  // Clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the held beat (if any) as a destination index plus payload, and a drop tally.
  logic [DW-1:0] exp_q[$];
  int            m_dest;
  int            m_drops;
  bit            m_known = 0;

  always @(posedge i_clk) begin
    bit m_drain;
    bit m_rdy;
    if (!i_rst_n) begin
      exp_q.delete();
      m_drops = 0;
      m_known = 1;
    end else if (m_known) begin
      m_drain = (exp_q.size() != 0) && out_ready[m_dest];
      m_rdy   = (exp_q.size() == 0) || m_drain;
      if (m_drain) void'(exp_q.pop_front());
      if (in_valid && m_rdy) begin
        if (i_Sel == 2'd3) begin
          if (m_drops < DROP_MAX) m_drops++;
        end else begin
          exp_q.push_back(in_data);
          m_dest = int'(i_Sel);
        end
      end
    end
  end

  // Compare process: every falling edge once the model is anchored by reset.
  always @(negedge i_clk) begin
    logic [2:0]    e_valid;
    logic [DW-1:0] e_data;
    logic          e_ready;
    if (m_known) begin
      e_valid = (exp_q.size() != 0) ? 3'(1 << m_dest) : 3'b000;
      e_data  = (exp_q.size() != 0) ? exp_q[0] : '0;
      e_ready = i_rst_n && ((exp_q.size() == 0) || ((e_valid & out_ready) != 3'b000));
      check("cmp_out_valid", 32'(out_valid), 32'(e_valid));
      check("cmp_out_data",  32'(out_data),  32'(e_data));
      check("cmp_in_ready",  32'(in_ready),  32'(e_ready));
      check("cmp_busy",      32'(busy),      32'(exp_q.size() != 0));
      check("cmp_drop_cnt",  32'(drop_cnt),  32'(m_drops));
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [DW-1:0] d,
                       input logic [2:0] rdy);
    in_valid  = v;
    i_Sel     = sel;
    in_data   = d;
    out_ready = rdy;
  endtask

  initial begin
    i_rst_n = 1'b0;
    drive(1'b1, 2'b00, 12'h5A5, 3'b111);

    // Reset with traffic pending
    step();
    step();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    drive(1'b0, 2'b00, 12'h000, 3'b111);
    i_rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Routing, back-to-back
    drive(1'b1, 2'b00, 12'h0A1, 3'b111);
    step();
    check("route1_valid", 32'(out_valid), 32'b001);
    check("route1_data",  32'(out_data),  32'h0A1);
    drive(1'b1, 2'b01, 12'h0B2, 3'b111);
    step();
    check("route2_valid", 32'(out_valid), 32'b010);
    check("route2_data",  32'(out_data),  32'h0B2);
    drive(1'b1, 2'b10, 12'h0C3, 3'b111);
    step();
    check("route3_valid", 32'(out_valid), 32'b100);
    check("route3_data",  32'(out_data),  32'h0C3);
    drive(1'b0, 2'b00, 12'h000, 3'b111);
    step();
    check("route_idle", 32'(out_valid), 32'b000);

    // Backpressure: non-selected ready bits must not drain
    drive(1'b1, 2'b01, 12'h123, 3'b101);
    step();
    drive(1'b1, 2'b10, 12'h777, 3'b101);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid",    32'(out_valid), 32'b010);
      check("bp_data",     32'(out_data),  32'h123);
      check("bp_in_ready", 32'(in_ready),  32'd0);
      check("bp_busy",     32'(busy),      32'd1);
      step();
    end
    drive(1'b0, 2'b00, 12'h000, 3'b111);
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_after_valid", 32'(out_valid), 32'b000);

    // Drops saturate
    drive(1'b1, 2'b11, 12'hFFF, 3'b111);
    for (int i = 0; i < 300; i++) begin
      in_data = DW'($urandom_range(0, 4095));
      step();
      if (i == 9) check("drop_cnt_10", 32'(drop_cnt), 32'd10);
    end
    drive(1'b0, 2'b00, 12'h000, 3'b111);
    check("drop_sat", 32'(drop_cnt), 32'd255);
    check("drop_no_valid", 32'(out_valid), 32'b000);

    // Drop code accepted while FULL and draining
    drive(1'b1, 2'b00, 12'h055, 3'b000);
    step();
    check("dfull_busy", 32'(busy), 32'd1);
    drive(1'b1, 2'b11, 12'h066, 3'b001);
    step();
    check("dfull_empty_busy",  32'(busy),      32'd0);
    check("dfull_empty_valid", 32'(out_valid), 32'b000);

    // New beat replaces the one draining in the same cycle
    drive(1'b1, 2'b10, 12'h111, 3'b000);
    step();
    check("b2b_first", 32'(out_data), 32'h111);
    drive(1'b1, 2'b00, 12'h222, 3'b100);
    step();
    check("b2b_valid", 32'(out_valid), 32'b001);
    check("b2b_data",  32'(out_data),  32'h222);
    drive(1'b0, 2'b00, 12'h000, 3'b111);
    step();

    // Reset mid-operation discards the held beat
    drive(1'b1, 2'b01, 12'h3FF, 3'b000);
    step();
    check("mid_held", 32'(out_valid), 32'b010);
    drive(1'b0, 2'b00, 12'h000, 3'b000);
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    check("mid_valid",    32'(out_valid), 32'b000);
    check("mid_data",     32'(out_data),  32'h000);
    check("mid_drop_cnt", 32'(drop_cnt),  32'd0);
    out_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_never_sent", 32'(out_valid), 32'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1x3_reg.md
# demux_1x3_reg

Registered 1-to-3 stream demultiplexer with valid/ready handshaking. It is the distribution-side counterpart of the core's 3-way select mux: it steers each accepted input beat to exactly one of three consumers, chosen by a 2-bit select. Select code 2'b11 is the unused code; beats carrying it are consumed and discarded, and the block counts them. A one-entry holding stage gives 1-cycle latency and full throughput.

## Interface
Parameters:
- DATA_WIDTH, 12, width of payload
- CNT_WIDTH, 8, width of drop counter

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- in_data  input  DATA_WIDTH  input payload
- i_Sel  input  2  destination: 00→port 1, 01→port 2, 10→port 3, 11→drop
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept a beat this cycle
- out_data  output  DATA_WIDTH  payload shared by all three ports
- out_valid  output  3  one-hot valid; bit0=port 1, bit1=port 2, bit2=port 3
- out_ready  input  3  per-port consumer ready; same bit mapping
- drop_cnt  output  CNT_WIDTH  saturating count of dropped (sel 11) beats
- busy  output  1  holding stage occupied

## Operation
- Two states: EMPTY, FULL. Holding registers: hold_data (DATA_WIDTH), hold_dest (3-bit one-hot).
- Accept: in_valid && in_ready at a rising edge.
- Drain: FULL && (out_valid & out_ready) != 0. out_ready bits of non-selected ports are ignored.
- in_ready = i_rst_n && (EMPTY || drain). It depends on neither in_valid nor i_Sel.
- Accept with i_Sel in {00,01,10}: load hold_data=in_data, hold_dest=one-hot of i_Sel, next state FULL. This holds even when draining in the same cycle (back-to-back).
- Accept with i_Sel=11: nothing loaded, drop_cnt increments by 1 and saturates at all-ones.
  - If FULL and draining in the same cycle, next state EMPTY.
  - If EMPTY, stay EMPTY.
- Drain without accept: next state EMPTY.
- FULL, no drain: hold all registers. Ignore in_data/i_Sel; in_ready=0.
- out_valid = hold_dest when FULL, else 3'b000.
- out_data = hold_data when FULL, else all zeros.
- busy = FULL.
- At most one out_valid bit is ever set. Beats leave in acceptance order; none are duplicated or lost, except sel 11 beats.

## Timing
- Reset (i_rst_n low at rising edge): state EMPTY, hold_data=0, hold_dest=000, drop_cnt=0. Therefore out_valid=000, out_data=0, busy=0.
- While i_rst_n is low, in_ready=0.
- Reset mid-operation discards any held beat without delivery. drop_cnt does not count it.
- Latency: a beat accepted at edge N is presented on out_valid/out_data from just after edge N.
- Throughput: 1 beat/cycle sustained while the selected consumer holds ready.
- Combinational path out_ready→in_ready is permitted. There is no path from in_valid or i_Sel to in_ready.
- While out_valid is set and not drained, out_data and out_valid stay stable.
- drop_cnt updates at the acceptance edge. It is visible the following cycle.

## Test plan
- Reset: hold i_rst_n=0 for 2 cycles with in_valid=1 and out_ready=111 → in_ready=0, out_valid=000, out_data=0, drop_cnt=0, busy=0. After release → in_ready=1.
- Routing: send 0x0A1 sel 00, 0x0B2 sel 01, 0x0C3 sel 10 on consecutive cycles, out_ready=111 → out_valid 001/010/100 on the following three cycles with matching data, no bubbles.
- Backpressure: send 0x123 sel 01 with out_ready=101 for 4 cycles → out_valid=010 and data 0x123 held; in_ready=0 and busy=1 throughout. Set out_ready[1]=1 → drain at that edge, in_ready=1 in the same cycle.
- Drop: send 300 beats sel 11 → no out_valid ever set, drop_cnt=255 (saturated).
  - Sel 11 accepted while FULL and draining → state EMPTY next cycle.
- Back-to-back under drain: FULL with 0x111 on port 3 and out_ready=100, new beat 0x222 sel 00 accepted in the same cycle → next cycle out_valid=001, data 0x222.
- Reset mid-operation: FULL with 0x3FF on port 2 and out_ready=000, assert i_rst_n=0 for one edge → out_valid=000 and out_data=0 afterward. 0x3FF is never delivered.
